xalu_muldiv: RTL and testbench
==============================

Name: xalu_muldiv

Overview:
- Multi-cycle multiply/divide unit (XALU) in the EX stage. Owns the architectural HI/LO registers.
- Executes mult/multu/div/divu and single-cycle mthi/mtlo.
- Drives `busy` into the hazard/stall logic. Decode stalls any HI/LO-family instruction while `busy` is high.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (range 1..16).
- DIV_CYCLES, 33, fixed busy cycles for div/divu: 32 radix-2 restoring iterations plus 1 sign-fix/write cycle. Localparam, not overridable.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  EX-stage instruction is an XALU op; qualified by `op`.
- op  in  3  operation code, encodings from xalu_pkg.
- src_a  in  32  rs value.
- src_b  in  32  rt value.
- flush  in  1  exception flush; aborts any in-flight op.
- busy  out  1  registered; high while a mult/div is in progress.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset: busy=0, hi=0, lo=0, FSM=IDLE, counter=0, operand and partial registers=0.
- States:
  - IDLE: accepts `start`.
  - MUL: counter counts down from MULT_CYCLES-1.
  - DIV: iterates 32 steps, then FIX.
  - FIX: applies signs, writes HI/LO.
- Accepted start at edge T0: busy=1 for exactly N cycles (edges T0+1..T0+N-1 keep it high). At edge T0+N, HI/LO are written and busy returns to 0 on the same edge. N = MULT_CYCLES for mult/multu, DIV_CYCLES for div/divu.
- HI/LO are never partially updated. The old values stay visible until the completing edge.
- mthi/mtlo: written at the same edge start is sampled. busy stays 0. The other register is untouched.
- start while busy=1: ignored, no state change. The stall unit guarantees this does not occur, and the bench asserts it.
- start with flush in the same cycle: ignored.
- flush while busy: return to IDLE at the next edge, busy=0, HI/LO keep their pre-op values.
- reset mid-operation: same as the reset values above.
- mult: signed 32x32→64. multu: unsigned. HI = product[63:32], LO = product[31:0].
- div:
  - Operands are converted to magnitudes at start.
  - Quotient truncates toward zero. The remainder takes the sign of the dividend.
  - LO = quotient, HI = remainder.
- divu: unsigned restoring division.
- Divide by zero (div and divu): LO = 0xFFFFFFFF, HI = src_a. The full 33 cycles are still taken.
- Signed overflow (0x80000000 / 0xFFFFFFFF): LO = 0x80000000, HI = 0.
- Operands are latched at start. src_a/src_b may change afterwards.

Optional Feature:
- Macro XALU_MADD_EN adds op codes madd, maddu, msub, msubu.
- Defined:
  - These ops compute the 64-bit product as mult/multu.
  - At completion {HI,LO} = {HI,LO} ± product, modulo 2^64.
  - Latency is MULT_CYCLES+1. The extra cycle is the accumulate stage.
  - flush behaviour is identical to mult.
- Not defined: these op codes behave as no-ops (no busy, no HI/LO change).

Decomposition:
- xalu_pkg holds:
  - op encodings: OP_MULT=0, OP_MULTU=1, OP_DIV=2, OP_DIVU=3, OP_MTHI=4, OP_MTLO=5, OP_MADD=6, OP_MSUB=7. Signedness for madd/msub is selected by an extra bit in the MADD build.
  - FSM state encoding.
  - DIV_CYCLES.
- Sub-module xalu_div_iter: 32-bit radix-2 restoring divider step datapath, holding the remainder/quotient registers, with load/step/done handshake. The top level owns the FSM, multiply path, HI/LO and flush.

Test Plan:
- Signed multiply: mult src_a=0xFFFFFFFE (-2), src_b=3 → busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. HI/LO unchanged during busy.
- Unsigned multiply: multu 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- Signed division: div -7 / 2 → after 33 busy cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu 100 / 7 → LO=14, HI=2.
- Edge-case division:
  - divu 5 / 0 → LO=0xFFFFFFFF, HI=5.
  - div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Flush, reset and move ops:
  - mthi 0x1234 then mtlo 0x5678 → no busy, HI=0x1234, LO=0x5678 next edge.
  - div started, flush at busy cycle 10 → busy=0 next edge, HI/LO still 0x1234/0x5678.
  - reset at busy cycle 3 → all outputs 0.
- Accumulate (XALU_MADD_EN only): HI/LO=0/10, madd 3×4 → after 6 cycles LO=22. msub 5×5 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.

Source files
------------

// File: rtl/xalu_pkg.sv
// Shared definitions for the XALU multiply/divide unit: op encodings, FSM states, latencies.
// Defining XALU_MADD_EN widens the op field by one bit that selects unsigned madd/msub.
package xalu_pkg;

`ifdef XALU_MADD_EN
    localparam int OP_W = 4;
`else
    localparam int OP_W = 3;
`endif

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MSUB  = 3'd7;

    localparam int DIV_CYCLES = 33;
    localparam int DIV_STEPS  = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } xalu_state_t;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/xalu_div_iter.sv
// 32-bit radix-2 restoring divider datapath; one quotient bit per step after a load.
// done is high during the step that produces the final (32nd) quotient bit.
module xalu_div_iter
    import xalu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic [5:0]  count_q;

    logic [32:0] shifted;
    logic        fits;
    logic [31:0] rem_next;

    // Shift the next dividend bit into the partial remainder and try the subtraction.
    always_comb begin
        shifted  = {rem_q, quo_q[31]};
        fits     = (shifted >= {1'b0, dvs_q});
        rem_next = fits ? 32'(shifted - {1'b0, dvs_q}) : shifted[31:0];
        done     = step && (count_q == 6'(DIV_STEPS - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            count_q <= '0;
        end else if (load) begin
            rem_q   <= '0;
            quo_q   <= dividend;
            dvs_q   <= divisor;
            count_q <= '0;
        end else if (step) begin
            rem_q   <= rem_next;
            quo_q   <= {quo_q[30:0], fits};
            count_q <= count_q + 6'd1;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/xalu_muldiv.sv
// XALU multiply/divide unit owning HI/LO; multi-cycle mult/div, single-cycle mthi/mtlo.
// Optional macro XALU_MADD_EN enables madd/maddu/msub/msubu accumulate ops.
module xalu_muldiv
    import xalu_pkg::*;
#(
    parameter int MULT_CYCLES = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [OP_W-1:0] op,
    input  logic [31:0]     src_a,
    input  logic [31:0]     src_b,
    input  logic            flush,
    output logic            busy,
    output logic [31:0]     hi,
    output logic [31:0]     lo
);

    localparam logic [4:0] MUL_LOAD = 5'(MULT_CYCLES - 1);
    localparam logic [4:0] ACC_LOAD = 5'(MULT_CYCLES);

    xalu_state_t state_q, state_d;
    logic [4:0]  cnt_q;
    logic [31:0] a_q, b_q;
    logic        mul_signed_q, acc_en_q, acc_sub_q;
    logic        neg_q_q, neg_r_q, div_zero_q;

    logic [2:0]  op_code;
    logic        accept, launch;
    logic        is_mul, is_div, is_mthi, is_mtlo, is_acc;
    logic        acc_unsigned, div_signed, launch_signed;
    logic        div_load, div_step, div_done, mul_done, fix_done;
    logic [31:0] div_dividend, div_divisor, div_quo, div_rem;
    logic [63:0] ext_a, ext_b, prod, acc_sum, mul_result;
    logic [31:0] fix_hi, fix_lo;

    // Instruction decode; only an idle, unflushed unit takes a new op.
    always_comb begin
        op_code    = op[2:0];
        accept     = start && !flush && (state_q == S_IDLE);
        is_mul     = (op_code == OP_MULT) || (op_code == OP_MULTU);
        is_div     = (op_code == OP_DIV) || (op_code == OP_DIVU);
        is_mthi    = (op_code == OP_MTHI);
        is_mtlo    = (op_code == OP_MTLO);
`ifdef XALU_MADD_EN
        is_acc       = (op_code == OP_MADD) || (op_code == OP_MSUB);
        acc_unsigned = op[3];
`else
        is_acc       = 1'b0;
        acc_unsigned = 1'b0;
`endif
        launch        = accept && (is_mul || is_acc || is_div);
        div_signed    = (op_code == OP_DIV);
        launch_signed = is_acc ? !acc_unsigned : (op_code == OP_MULT);
        div_dividend  = div_signed ? abs32(src_a) : src_a;
        div_divisor   = div_signed ? abs32(src_b) : src_b;
    end

    always_comb begin
        state_d  = state_q;
        div_load = 1'b0;
        div_step = 1'b0;
        mul_done = 1'b0;
        fix_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    if (is_div) begin
                        state_d  = S_DIV;
                        div_load = 1'b1;
                    end else begin
                        state_d = S_MUL;
                    end
                end
            end
            S_MUL: begin
                if (cnt_q == 5'd0) begin
                    state_d  = S_IDLE;
                    mul_done = 1'b1;
                end
            end
            S_DIV: begin
                div_step = 1'b1;
                if (div_done) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d  = S_IDLE;
                fix_done = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        // A flush abandons the op before any HI/LO write can happen.
        if (flush) begin
            state_d  = S_IDLE;
            div_load = 1'b0;
            div_step = 1'b0;
            mul_done = 1'b0;
            fix_done = 1'b0;
        end
    end

    // The low 64 bits of a 64x64 product of extended operands are correct for both signednesses.
    always_comb begin
        ext_a      = {{32{mul_signed_q & a_q[31]}}, a_q};
        ext_b      = {{32{mul_signed_q & b_q[31]}}, b_q};
        prod       = ext_a * ext_b;
        acc_sum    = acc_sub_q ? ({hi, lo} - prod) : ({hi, lo} + prod);
        mul_result = acc_en_q ? acc_sum : prod;
        if (div_zero_q) begin
            fix_hi = a_q;
            fix_lo = 32'hFFFF_FFFF;
        end else begin
            fix_hi = neg_r_q ? (~div_rem + 32'd1) : div_rem;
            fix_lo = neg_q_q ? (~div_quo + 32'd1) : div_quo;
        end
    end

    xalu_div_iter u_div (
        .clk       (clk),
        .reset     (reset),
        .load      (div_load),
        .step      (div_step),
        .dividend  (div_dividend),
        .divisor   (div_divisor),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            busy         <= 1'b0;
            hi           <= '0;
            lo           <= '0;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            mul_signed_q <= 1'b0;
            acc_en_q     <= 1'b0;
            acc_sub_q    <= 1'b0;
            neg_q_q      <= 1'b0;
            neg_r_q      <= 1'b0;
            div_zero_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != S_IDLE);
            if (launch) begin
                a_q          <= src_a;
                b_q          <= src_b;
                mul_signed_q <= launch_signed;
                acc_en_q     <= is_acc;
                acc_sub_q    <= is_acc && (op_code == OP_MSUB);
                neg_q_q      <= div_signed && (src_a[31] ^ src_b[31]);
                neg_r_q      <= div_signed && src_a[31];
                div_zero_q   <= (src_b == 32'd0);
                cnt_q        <= is_acc ? ACC_LOAD : MUL_LOAD;
            end else if ((state_q == S_MUL) && (cnt_q != 5'd0)) begin
                cnt_q <= cnt_q - 5'd1;
            end
            if (accept && is_mthi) begin
                hi <= src_a;
            end
            if (accept && is_mtlo) begin
                lo <= src_a;
            end
            if (mul_done) begin
                {hi, lo} <= mul_result;
            end
            if (fix_done) begin
                hi <= fix_hi;
                lo <= fix_lo;
            end
        end
    end

endmodule

// File: tb/tb_xalu_muldiv.sv
// Self-checking bench for xalu_muldiv: directed vector table, flush/reset sequences, random ops vs model.
module tb_xalu_muldiv;
    import xalu_pkg::*;

    localparam int MULT_N = 5;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [OP_W-1:0] op = '0;
    logic [31:0]     src_a = '0;
    logic [31:0]     src_b = '0;
    logic            flush = 1'b0;
    logic            busy;
    logic [31:0]     hi, lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[9];

    xalu_muldiv #(.MULT_CYCLES(MULT_N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .flush (flush),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    // The stall unit never issues an XALU op while busy; the bench must honour that too.
    always @(posedge clk) begin
        if (start && busy && !reset) begin
            errors++;
            $display("[TB] FAIL start_while_busy: start=%0b busy=%0b required no overlap", start, busy);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Issues one op for a single cycle, scrambles operands afterwards, and counts busy cycles.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output int cyc, output logic held);
        logic [31:0] hi0, lo0;
        @(negedge clk);
        hi0   = hi;
        lo0   = lo;
        held  = 1'b1;
        start = 1'b1;
        op    = OP_W'(o);
        src_a = a;
        src_b = b;
        @(negedge clk);
        start = 1'b0;
        src_a = $urandom;
        src_b = $urandom;
        cyc   = 0;
        while (busy && cyc < 100) begin
            if (hi !== hi0 || lo !== lo0) held = 1'b0;
            cyc++;
            @(negedge clk);
        end
    endtask

    function automatic void refModel(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] hi_in, input logic [31:0] lo_in,
                                     output logic [31:0] hi_out, output logic [31:0] lo_out,
                                     output int cyc);
        longint          sp;
        logic [63:0]     up;
        hi_out = hi_in;
        lo_out = lo_in;
        cyc    = 0;
        case (o)
            OP_MULT: begin
                sp = longint'(int'(a)) * longint'(int'(b));
                {hi_out, lo_out} = sp;
                cyc = MULT_N;
            end
            OP_MULTU: begin
                up = {32'd0, a} * {32'd0, b};
                {hi_out, lo_out} = up;
                cyc = MULT_N;
            end
            OP_DIV: begin
                cyc = DIV_CYCLES;
                if (b == 32'd0) begin
                    lo_out = 32'hFFFF_FFFF;
                    hi_out = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo_out = 32'h8000_0000;
                    hi_out = 32'd0;
                end else begin
                    lo_out = int'(a) / int'(b);
                    hi_out = int'(a) % int'(b);
                end
            end
            OP_DIVU: begin
                cyc = DIV_CYCLES;
                if (b == 32'd0) begin
                    lo_out = 32'hFFFF_FFFF;
                    hi_out = a;
                end else begin
                    lo_out = a / b;
                    hi_out = a % b;
                end
            end
            OP_MTHI: hi_out = a;
            OP_MTLO: lo_out = a;
            default: ;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          cyc;
        logic        held;
        logic [31:0] m_hi, m_lo, e_hi, e_lo;
        int          e_cyc;
        logic [2:0]  r_op;
        logic [31:0] r_a, r_b;

        vecs[0] = '{"mult_neg",   OP_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, MULT_N};
        vecs[1] = '{"multu_max",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MULT_N};
        vecs[2] = '{"mult_min",   OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MULT_N};
        vecs[3] = '{"div_m7_2",   OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_CYCLES};
        vecs[4] = '{"div_7_m2",   OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DIV_CYCLES};
        vecs[5] = '{"divu_100_7", OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        DIV_CYCLES};
        vecs[6] = '{"divu_by0",   OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, DIV_CYCLES};
        vecs[7] = '{"div_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, DIV_CYCLES};
        vecs[8] = '{"div_by0",    OP_DIV,   32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF, DIV_CYCLES};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, cyc, held);
            checkOutput({vecs[i].name, "_cycles"}, 32'(cyc), 32'(vecs[i].exp_cyc));
            checkOutput({vecs[i].name, "_held"}, 32'(held), 32'd1);
            checkOutput({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
            checkOutput({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
        end

        applyStimulus(OP_MTHI, 32'h1234, 32'h0, cyc, held);
        checkOutput("mthi_cycles", 32'(cyc), 32'd0);
        checkOutput("mthi_hi", hi, 32'h1234);
        checkOutput("mthi_lo_kept", lo, 32'hFFFF_FFFF);
        applyStimulus(OP_MTLO, 32'h5678, 32'h0, cyc, held);
        checkOutput("mtlo_cycles", 32'(cyc), 32'd0);
        checkOutput("mtlo_hi_kept", hi, 32'h1234);
        checkOutput("mtlo_lo", lo, 32'h5678);

        applyStimulus(OP_MADD, 32'd3, 32'd4, cyc, held);
        checkOutput("madd_noop_cycles", 32'(cyc), 32'd0);
        checkOutput("madd_noop_hi", hi, 32'h1234);
        checkOutput("madd_noop_lo", lo, 32'h5678);

        // Flush a divide on its 10th busy cycle.
        @(negedge clk);
        start = 1'b1; op = OP_W'(OP_DIV); src_a = 32'd100; src_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        checkOutput("flush_div_busy", 32'(busy), 32'd1);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_busy", 32'(busy), 32'd0);
        repeat (40) @(negedge clk);
        checkOutput("flush_hi", hi, 32'h1234);
        checkOutput("flush_lo", lo, 32'h5678);

        // start together with flush must be ignored.
        start = 1'b1; flush = 1'b1; op = OP_W'(OP_MULT); src_a = 32'd3; src_b = 32'd3;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        checkOutput("startflush_busy", 32'(busy), 32'd0);
        repeat (8) @(negedge clk);
        checkOutput("startflush_lo", lo, 32'h5678);

        // Reset on the third busy cycle of a multiply.
        start = 1'b1; op = OP_W'(OP_MULT); src_a = 32'd9; src_b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("prereset_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_hi", hi, 32'd0);
        checkOutput("midreset_lo", lo, 32'd0);
        repeat (8) @(negedge clk);
        checkOutput("midreset_lo_later", lo, 32'd0);

        m_hi = 32'd0;
        m_lo = 32'd0;
        for (int n = 0; n < 40; n++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            case ($urandom_range(0, 7))
                0:       r_b = 32'd0;
                1:       r_b = 32'hFFFF_FFFF;
                2, 3:    r_b = 32'($urandom_range(1, 50));
                default: r_b = $urandom;
            endcase
            if (n == 5) begin
                r_op = OP_DIV; r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF;
            end
            refModel(r_op, r_a, r_b, m_hi, m_lo, e_hi, e_lo, e_cyc);
            applyStimulus(r_op, r_a, r_b, cyc, held);
            checkOutput($sformatf("rand%0d_op%0d_cycles", n, r_op), 32'(cyc), 32'(e_cyc));
            checkOutput($sformatf("rand%0d_op%0d_held", n, r_op), 32'(held), 32'd1);
            checkOutput($sformatf("rand%0d_op%0d_hi", n, r_op), hi, e_hi);
            checkOutput($sformatf("rand%0d_op%0d_lo", n, r_op), lo, e_lo);
            m_hi = e_hi;
            m_lo = e_lo;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
